// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - period and high-time meter for a slow asynchronous input
module freq_meter #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             meas_en,
  input  logic             ready,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             overflow,
  output logic             valid,
  output logic             missed
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    ARM,
    MEASURE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_hcnt;
  logic                   r_sat;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       r_high;
  logic                   r_ovf;
  logic                   r_valid;
  logic                   r_missed;

  logic                   w_s;
  logic                   w_rise;
  logic [WIDTH-1:0]       w_cnt_inc;
  logic [WIDTH-1:0]       w_hcnt_inc;
  logic                   w_cnt_hit;
  logic                   w_hcnt_hit;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  // Saturating increments: counters park at the maximum instead of wrapping
  assign w_cnt_inc  = (r_cnt  == CNT_MAX) ? CNT_MAX : r_cnt  + CNT_ONE;
  assign w_hcnt_inc = (r_hcnt == CNT_MAX) ? CNT_MAX : r_hcnt + CNT_ONE;
  assign w_cnt_hit  = (w_cnt_inc == CNT_MAX);
  assign w_hcnt_hit = w_s && (w_hcnt_inc == CNT_MAX);

  // Synchronize d_in and keep a one-cycle-delayed copy for rise detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
      r_s_d  <= w_s;
    end
  end

  // Measurement FSM with counters, result registers and valid/ready handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_sat    <= 1'b0;
      r_period <= '0;
      r_high   <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_missed <= 1'b0;
    end else if (!meas_en) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_sat    <= 1'b0;
      r_period <= '0;
      r_high   <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      // A completed transfer retires the result unless a capture below reloads it
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_hcnt  <= '0;
          r_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // Skip a period already in progress when measurement starts
          if (!w_s) begin
            r_state <= ARM;
          end
        end
        ARM: begin
          if (w_rise) begin
            r_cnt   <= CNT_ONE;
            r_hcnt  <= CNT_ONE;
            r_sat   <= 1'b0;
            r_state <= MEASURE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            r_cnt  <= CNT_ONE;
            r_hcnt <= CNT_ONE;
            r_sat  <= 1'b0;
            if (!r_valid || ready) begin
              r_period <= r_cnt;
              r_high   <= r_hcnt;
              r_ovf    <= r_sat;
              r_valid  <= 1'b1;
            end else begin
              // Consumer still holds the previous result: drop this one
              r_missed <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_s) begin
              r_hcnt <= w_hcnt_inc;
            end
            r_sat <= r_sat | w_cnt_hit | w_hcnt_hit;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign overflow  = r_ovf;
  assign valid     = r_valid;
  assign missed    = r_missed;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter
module tb_freq_meter;

  localparam int MAX24 = 2**24 - 1;
  localparam int MAX8  = 255;

  typedef struct {
    int p;
    int hi;
    bit ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        d_in = 1'b0;
  logic        meas_en = 1'b0;
  logic        ready = 1'b1;

  logic [23:0] period24;
  logic [23:0] high24;
  logic        ovf24;
  logic        valid24;
  logic        missed24;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        ovf8;
  logic        valid8;
  logic        missed8;

  int   n_checks = 0;
  int   n_pass = 0;
  bit   sb_on = 1'b0;
  bit   have_prev = 1'b0;
  int   prev_h = 0;
  int   prev_l = 0;
  res_t q24[$];
  res_t q8[$];
  res_t e24;
  res_t e8;

  always #5 clk = ~clk;

  freq_meter #(.WIDTH(24), .SYNC_STAGES(2)) u_dut24 (
    .clk(clk), .rst(rst), .d_in(d_in), .meas_en(meas_en), .ready(ready),
    .period(period24), .high_time(high24), .overflow(ovf24),
    .valid(valid24), .missed(missed24)
  );

  freq_meter #(.WIDTH(8), .SYNC_STAGES(3)) u_dut8 (
    .clk(clk), .rst(rst), .d_in(d_in), .meas_en(meas_en), .ready(ready),
    .period(period8), .high_time(high8), .overflow(ovf8),
    .valid(valid8), .missed(missed8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: a period of h high then l low cycles, judged against a counter limit
  function automatic res_t expect_res(input int h, input int l, input int mx);
    res_t r;
    r.p  = (h + l >= mx) ? mx : h + l;
    r.hi = (h >= mx) ? mx : h;
    r.ov = (h + l >= mx);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input period starting with a rise; that rise completes the previous period
  task automatic wave(input int h, input int l);
    if (sb_on && have_prev) begin
      q24.push_back(expect_res(prev_h, prev_l, MAX24));
      q8.push_back(expect_res(prev_h, prev_l, MAX8));
    end
    prev_h = h;
    prev_l = l;
    have_prev = 1'b1;
    d_in = 1'b1;
    repeat (h) tick();
    d_in = 1'b0;
    repeat (l) tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_period24"}, period24, 0);
    check({tag, "_high24"}, high24, 0);
    check({tag, "_ovf24"}, ovf24, 0);
    check({tag, "_valid24"}, valid24, 0);
    check({tag, "_missed24"}, missed24, 0);
    check({tag, "_valid8"}, valid8, 0);
    check({tag, "_period8"}, period8, 0);
  endtask

  // Scoreboard: every accepted transfer must match the next modelled result
  always @(negedge clk) begin
    if (sb_on && rst && meas_en && ready) begin
      if (valid24) begin
        if (q24.size() == 0) check("spurious24", valid24, 0);
        else begin
          e24 = q24.pop_front();
          check("period24", period24, e24.p);
          check("high24", high24, e24.hi);
          check("ovf24", ovf24, e24.ov);
          check("missed24", missed24, 0);
        end
      end
      if (valid8) begin
        if (q8.size() == 0) check("spurious8", valid8, 0);
        else begin
          e8 = q8.pop_front();
          check("period8", period8, e8.p);
          check("high8", high8, e8.hi);
          check("ovf8", ovf8, e8.ov);
          check("missed8", missed8, 0);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    check_cleared("reset");
    rst = 1'b1;
    sb_on = 1'b1;
    meas_en = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 6; i++) wave(8, 8);
    for (int i = 0; i < 5; i++) wave(3, 7);
    for (int i = 0; i < 30; i++) wave($urandom_range(1, 30), $urandom_range(1, 30));
    wave(150, 150);
    wave(10, 10);
    wave(10, 10);
    for (int i = 0; i < 3; i++) wave(7, 5);
    check("drain24_a", q24.size(), 0);
    check("drain8_a", q8.size(), 0);

    // Reset during the low phase of a measured period
    rst = 1'b0;
    tick();
    rst = 1'b1;
    have_prev = 1'b0;
    check_cleared("midrst");
    repeat (6) tick();
    for (int i = 0; i < 4; i++) wave(7, 5);
    repeat (12) tick();
    check("drain24_b", q24.size(), 0);
    check("drain8_b", q8.size(), 0);

    // Backpressure: first result held, later ones dropped
    sb_on = 1'b0;
    ready = 1'b0;
    meas_en = 1'b0;
    tick();
    meas_en = 1'b1;
    repeat (4) tick();
    wave(8, 8);
    wave(8, 8);
    wave(5, 7);
    d_in = 1'b1;
    repeat (4) tick();
    check("bp_valid24", valid24, 1);
    check("bp_period24", period24, 16);
    check("bp_high24", high24, 8);
    check("bp_missed24", missed24, 1);
    check("bp_period8", period8, 16);
    check("bp_missed8", missed8, 1);
    ready = 1'b1;
    tick();
    check("bp_valid_after24", valid24, 0);
    check("bp_missed_after24", missed24, 1);
    check("bp_valid_after8", valid8, 0);
    repeat (2) tick();
    d_in = 1'b0;
    repeat (8) tick();
    wave(6, 6);
    d_in = 1'b1;
    repeat (6) tick();
    check("bp_sticky24", missed24, 1);
    meas_en = 1'b0;
    tick();
    check_cleared("en_drop");
    check("en_drop_missed8", missed8, 0);

    // Input already high when measurement is enabled
    repeat (2) tick();
    q24.delete();
    q8.delete();
    have_prev = 1'b0;
    sb_on = 1'b1;
    meas_en = 1'b1;
    repeat (10) tick();
    check("hi_start_valid24", valid24, 0);
    d_in = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) wave(6, 6);
    wave(4, 4);
    repeat (10) tick();
    check("drain24_c", q24.size(), 0);
    check("drain8_c", q8.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the period and high time of a slow digital input, counted in clk cycles. Typical sources are the divided output of freqDivider or an external pulse. It is the consuming end of the divided-clock path and is used to confirm divider ratios and duty cycle on hardware. Results go out through a valid/ready handshake to a register file or display driver.

Parameters:
WIDTH, 24, width of the period/high-time counters and result buses
SYNC_STAGES, 2, flops in the d_in synchronizer (legal values 2..4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge)
d_in  input  1  asynchronous signal under measurement
meas_en  input  1  1 = measure, 0 = idle/clear
ready  input  1  consumer accepts result when ready=1 and valid=1 at a clk edge
period  output  WIDTH  cycles between consecutive synchronized rising edges
high_time  output  WIDTH  cycles the synchronized input was high within that period
overflow  output  1  result saturated, qualified by valid
valid  output  1  result available
missed  output  1  sticky: at least one result was dropped because of backpressure

Behaviour:
- Reset (rst=0 at a clk edge):
  - period=0, high_time=0, overflow=0, valid=0, missed=0.
  - Synchronizer flops, edge register and counters cleared.
  - FSM goes to IDLE.
  - Reset wins over every other event in the same cycle. Reset mid-measurement discards the partial count.
- Synchronizer: SYNC_STAGES flops on d_in give s. A delayed copy s_d gives rise = s & ~s_d (combinational, one cycle wide).
- FSM:
  - IDLE: counters held at 0, valid forced 0. Go to WAIT_LOW when meas_en=1.
  - WAIT_LOW: wait for s=0. This blocks a partial first period when d_in is already high. Go to ARM when s=0.
  - ARM: on rise, load cnt=1, hcnt=1, go to MEASURE. Nothing is published.
  - MEASURE:
    - cnt increments every cycle.
    - hcnt increments on cycles where s=1 and rise=0, and holds otherwise.
    - On rise: capture period=cnt, high_time=hcnt, overflow=sat_flag; reload cnt=1, hcnt=1; clear sat_flag; stay in MEASURE.
  - Any state: meas_en=0 goes to IDLE next edge and clears valid. missed also clears while meas_en=0.
- Saturation: cnt and hcnt stop at 2^WIDTH-1 and never wrap. Reaching the max sets sat_flag, which is reported as overflow with the next result.
- Latency: d_in high sampled at edge k gives rise during the cycle after edge k+SYNC_STAGES-1. Outputs update at edge k+SYNC_STAGES.
- Result definition: for rises at cycles t0 and t1, period=t1-t0. A square wave toggling every N cycles gives period=2N, high_time=N.
- Handshake:
  - valid rises at the capture edge.
  - period, high_time and overflow stay stable while valid=1 and ready=0.
  - An edge with valid=1 and ready=1 completes the transfer, and valid drops next cycle.
  - If that same edge is also a capture edge, new data loads and valid stays 1.
  - Capture while valid=1 and ready=0: the new result is discarded, the held result is kept, and missed is set.
  - ready is ignored when valid=0.
- There are no combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=24, SYNC_STAGES=2; d_in square wave toggling every 8 cycles; ready=1 -> first result appears after the second rise, then one result every 16 cycles with period=16, high_time=8, overflow=0, missed=0.
- d_in high 3 cycles / low 7 cycles; ready=1 -> period=10, high_time=3 on every result.
- WIDTH=8; d_in period 300 (high 150) -> period=255, high_time=150, overflow=1. Then switch to period 20 -> next result has period=20, overflow=0.
- d_in period 16; ready=0 for 40 cycles, then ready=1 -> first result held stable and missed=1. After the transfer, valid falls unless a capture coincides; missed stays 1 until meas_en=0.
- d_in held high when meas_en rises; d_in then falls and resumes period 12 -> no result until two full rises after the low is seen. First result is period=12.
- Drive rst=0 for 1 cycle mid-MEASURE, and separately drop meas_en for 1 cycle -> next edge all outputs are 0 and valid=0. After re-enable, the first valid result needs WAIT_LOW, then ARM, then a full period.
